// File: rtl/id_stage_hs.sv
// id_stage_hs: MIPS-subset decode stage with valid/ready handshake on both sides.
// Decodes one instruction per cycle into an operand/control bundle held in an
// output register (one-cycle latency). Stalls on load-use hazards against an lw
// sitting in EX, inserting a bubble and counting stall cycles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready combinational)
//   instr, pc_in             instruction word, PC of next sequential instr
//   rs_data1/2               register-file reads for rs / rt
//   ex_load_valid/rd         lw in EX and its destination
//   flush                    drop held and incoming instruction
//   out_valid/out_ready      downstream handshake
//   op1..illegal             registered decoded bundle
//   stall_cnt                saturating count of load-use stall cycles
module id_stage_hs #(
  parameter int XLEN       = 32,
  parameter int ZEXT_LOGIC = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc_in,
  input  logic [XLEN-1:0]  rs_data1,
  input  logic [XLEN-1:0]  rs_data2,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_load_rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op1,
  output logic [XLEN-1:0]  op2,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [2:0]       alu_func,
  output logic [1:0]       mem_op,
  output logic [1:0]       br_type,
  output logic [31:0]      br_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] ALU_NOP = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3,
                         ALU_OR  = 3'd4, ALU_XOR = 3'd5, ALU_NOR = 3'd6, ALU_SRA = 3'd7;
  localparam logic [1:0] MEM_NONE = 2'd0, MEM_LW = 2'd1, MEM_SW = 2'd2;
  localparam logic [1:0] BR_NO = 2'd0, BR_EQ = 2'd1, BR_NEQ = 2'd2, BR_GTZ = 2'd3;

  logic [5:0]      w_opcode, w_funct;
  logic [4:0]      w_rs, w_rt;
  logic [XLEN-1:0] w_sext, w_zext, w_imm;
  logic [2:0]      w_alu;
  logic [1:0]      w_mem, w_br;
  logic            w_ill, w_use_imm, w_logic_imm, w_is_sra, w_uses_rt, w_is_j, w_is_jr;
  logic            w_hazard, w_slot_free, w_accept, w_stall;

  logic [XLEN-1:0]  r_op1, r_op2;
  logic [4:0]       r_rd, r_shamt;
  logic [2:0]       r_alu;
  logic [1:0]       r_mem, r_br;
  logic [31:0]      r_br_target, r_redirect_pc;
  logic             r_out_valid, r_redirect_valid, r_illegal;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_sext   = {{(XLEN-16){instr[15]}}, instr[15:0]};
  assign w_zext   = {{(XLEN-16){1'b0}}, instr[15:0]};
  assign w_imm    = (w_logic_imm && (ZEXT_LOGIC != 0)) ? w_zext : w_sext;

  always_comb begin
    w_alu       = ALU_NOP;
    w_mem       = MEM_NONE;
    w_br        = BR_NO;
    w_ill       = 1'b0;
    w_use_imm   = 1'b0;
    w_logic_imm = 1'b0;
    w_is_sra    = 1'b0;
    w_uses_rt   = 1'b0;
    w_is_j      = 1'b0;
    w_is_jr     = 1'b0;
    case (w_opcode)
      6'h00: begin
        // Every R-type reads rt, even ones that turn out illegal.
        w_uses_rt = 1'b1;
        case (w_funct)
          6'h20: w_alu = ALU_ADD;
          6'h22: w_alu = ALU_SUB;
          6'h03: begin w_alu = ALU_SRA; w_is_sra = 1'b1; end
          6'h24: w_alu = ALU_AND;
          6'h25: w_alu = ALU_OR;
          6'h26: w_alu = ALU_XOR;
          6'h27: w_alu = ALU_NOR;
          6'h08: w_is_jr = 1'b1;
          default: w_ill = 1'b1;
        endcase
      end
      6'h08: begin w_alu = ALU_ADD; w_use_imm = 1'b1; end
      6'h0C: begin w_alu = ALU_AND; w_use_imm = 1'b1; w_logic_imm = 1'b1; end
      6'h0D: begin w_alu = ALU_OR;  w_use_imm = 1'b1; w_logic_imm = 1'b1; end
      6'h0E: begin w_alu = ALU_XOR; w_use_imm = 1'b1; w_logic_imm = 1'b1; end
      6'h02: w_is_j = 1'b1;
      6'h04: begin w_alu = ALU_SUB; w_br = BR_EQ;  w_uses_rt = 1'b1; end
      6'h05: begin w_alu = ALU_SUB; w_br = BR_NEQ; w_uses_rt = 1'b1; end
      6'h07: begin w_alu = ALU_SUB; w_br = BR_GTZ; end
      6'h23: begin w_alu = ALU_ADD; w_mem = MEM_LW; w_use_imm = 1'b1; end
      6'h2B: begin w_alu = ALU_ADD; w_mem = MEM_SW; w_use_imm = 1'b1; w_uses_rt = 1'b1; end
      default: w_ill = 1'b1;
    endcase
  end

  // Load-use: the lw result is not yet forwardable, so hold the consumer.
  assign w_hazard    = ex_load_valid && (ex_load_rd != 5'd0) &&
                       ((ex_load_rd == w_rs) || (w_uses_rt && (ex_load_rd == w_rt)));
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !rst && !flush && !w_hazard && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_stall     = in_valid && w_hazard && w_slot_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_op1            <= '0;
      r_op2            <= '0;
      r_rd             <= '0;
      r_shamt          <= '0;
      r_alu            <= ALU_NOP;
      r_mem            <= MEM_NONE;
      r_br             <= BR_NO;
      r_br_target      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_illegal        <= 1'b0;
      r_stall_cnt      <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid      <= 1'b1;
      r_op1            <= rs_data1;
      r_op2            <= w_use_imm ? w_imm : rs_data2;
      r_rd             <= (w_opcode == 6'h00) ? instr[15:11] : w_rt;
      r_shamt          <= w_is_sra ? instr[10:6] : 5'd0;
      r_alu            <= w_alu;
      r_mem            <= w_mem;
      r_br             <= w_br;
      r_br_target      <= pc_in + {{14{instr[15]}}, instr[15:0], 2'b00};
      r_redirect_valid <= w_is_j || w_is_jr;
      r_redirect_pc    <= w_is_j  ? {pc_in[31:28], instr[25:0], 2'b00} :
                          w_is_jr ? rs_data1[31:0] : 32'd0;
      r_illegal        <= w_ill;
    end else if (w_stall) begin
      // Bubble out; downstream sees nothing while the consumer waits.
      r_out_valid <= 1'b0;
      if (r_stall_cnt != {CNT_W{1'b1}})
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign op1            = r_op1;
  assign op2            = r_op2;
  assign rd             = r_rd;
  assign shamt          = r_shamt;
  assign alu_func       = r_alu;
  assign mem_op         = r_mem;
  assign br_type        = r_br;
  assign br_target      = r_br_target;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign illegal        = r_illegal;
  assign stall_cnt      = r_stall_cnt;

endmodule
